jedro_1_mem_arbiter: RTL
========================

Name: jedro_1_mem_arbiter

Overview:
- Shares one single-port, byte-writable data RAM between two requesters: the core's instruction fetch port (M0) and its load/store port (M1).
- Sits between jedro_1_top's memory interfaces and the bytewrite RAM, so a unified-memory system needs only one RAM instance.
- Arbitration is round-robin with one grant per cycle. Responses are fully pipelined with a fixed one-cycle read latency.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports.
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).
- MEM_WORDS, 1024, RAM depth in words; word addresses at or above MEM_WORDS are out of range.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_req_i  in  1  fetch request.
- m0_addr_i  in  ADDR_WIDTH  fetch byte address.
- m0_gnt_o  out  1  fetch request accepted this cycle.
- m0_rvalid_o  out  1  fetch response valid.
- m0_rdata_o  out  DATA_WIDTH  fetch read data.
- m0_err_o  out  1  fetch response is an out-of-range error (qualified by m0_rvalid_o).
- m1_req_i  in  1  load/store request.
- m1_we_i  in  1  1 = store, 0 = load.
- m1_be_i  in  4  store byte enables.
- m1_addr_i  in  ADDR_WIDTH  load/store byte address.
- m1_wdata_i  in  DATA_WIDTH  store data.
- m1_gnt_o  out  1  load/store request accepted.
- m1_rvalid_o  out  1  load data valid, or store acknowledge.
- m1_rdata_o  out  DATA_WIDTH  load read data.
- m1_err_o  out  1  load/store response is an out-of-range error.
- ram_en_o  out  1  RAM access enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_addr_o  out  ADDR_WIDTH-2  RAM word address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

Behaviour:
- Requester protocol:
  - A requester holds req, addr, we, be and wdata stable until it sees gnt.
  - gnt is combinational from req and the arbiter state, in the same cycle.
  - A request is transferred when req and gnt are both high at a clock edge.
- State registers:
  - last_q (0 = M0 last won, 1 = M1 last won).
  - resp_owner_q (none/M0/M1).
  - resp_err_q.
- Arbitration, per cycle:
  - Only one requester asserting req: it is granted.
  - Both asserting req: the requester that did not win last_q is granted.
  - last_q updates only on a granted transfer.
  - No combinational path from ram_rdata_i to any gnt.
- Address mapping:
  - ram_addr_o = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - Word address >= MEM_WORDS: the request is still granted, but ram_en_o = 0 and ram_we_o = 0. The response carries err = 1 and rdata = 0.
- RAM drive on a granted transfer:
  - ram_en_o = 1.
  - ram_we_o = m1_be_i if M1 store, else 0.
  - ram_wdata_o = m1_wdata_i.
- No grant that cycle: ram_en_o = 0 and ram_we_o = 0; ram_addr_o and ram_wdata_o are don't-care but held at 0.
- Response timing:
  - Exactly one cycle after a transfer, the owner's rvalid pulses for one cycle.
  - rdata passes through ram_rdata_i, or 0 on error.
  - Stores also produce an rvalid (write acknowledge) with rdata = 0.
  - Back-to-back transfers give back-to-back rvalids; throughput is 1 access per cycle.
  - The non-owner's rvalid, err and rdata are 0.
- Reset (rst_i high at an edge):
  - last_q = 1, so M0 wins the first conflict.
  - resp_owner_q = none.
- While rst_i is high:
  - m0_gnt_o and m1_gnt_o are forced to 0.
  - ram_en_o and ram_we_o are forced to 0.
- Reset mid-operation: an in-flight response is discarded; no rvalid in the cycle after the reset edge.
- A request dropped before gnt is legal; it has no effect and does not update last_q.
- Assertion (sim only): req must not deassert, and addr must not change, while req is high and gnt is low.

Test Plan:
- Single fetch, no conflict:
  - Preload word 5 = 0xDEADBEEF; M0 reads addr 0x14.
  - Expect m0_gnt_o in the same cycle, m0_rvalid_o next cycle with rdata 0xDEADBEEF, m0_err_o = 0.
- Store then load:
  - M1 stores 0x000000AB, be = 4'b0001, at addr 0x08 over old value 0x11223344; expect write-ack rvalid.
  - M1 then loads 0x08; expect rdata 0x112233AB.
- Persistent conflict:
  - Both requesters hold req for 6 cycles after reset.
  - Expect grant order M0, M1, M0, M1, M0, M1, one grant per cycle.
  - Expect rvalids alternate with one-cycle lag, with no gap cycles.
- Out of range:
  - MEM_WORDS = 1024; M1 loads addr 0x1000.
  - Expect gnt, ram_en_o = 0, then m1_rvalid_o = 1, m1_err_o = 1, rdata = 0.
  - Repeat as a store; expect RAM contents unchanged.
- Reset mid-flight:
  - Grant an M0 read, assert rst_i on the next edge.
  - Expect no m0_rvalid_o, all gnt = 0 during reset.
  - Expect the first post-reset conflict granted to M0.
- Misaligned address: M0 reads 0x17; expect the word-5 data (low bits ignored).

Source files
------------

// File: rtl/jedro_1_mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte-writable RAM between the
// instruction fetch port (M0) and the load/store port (M1), one-cycle read latency.
module jedro_1_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,

  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned     WordW     = ADDR_WIDTH - 2;
  localparam logic [WordW-1:0] MemWordsW = WordW'(MEM_WORDS);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  logic   last_q, last_d;
  owner_e resp_owner_q, resp_owner_d;
  logic   resp_err_q, resp_err_d;
  logic   resp_zero_q, resp_zero_d;

  logic             granted;
  logic             in_range;
  logic [WordW-1:0] sel_word;
  logic [DATA_WIDTH-1:0] resp_data;

  // Byte-offset bits never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // last_q == 1 means M1 won last, so M0 takes the next conflict.
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (!rst_i) begin
      m0_gnt_o = m0_req_i && (!m1_req_i || last_q);
      m1_gnt_o = m1_req_i && (!m0_req_i || !last_q);
    end
  end

  assign granted  = m0_gnt_o | m1_gnt_o;
  assign sel_word = m1_gnt_o ? m1_addr_i[ADDR_WIDTH-1:2] : m0_addr_i[ADDR_WIDTH-1:2];
  assign in_range = (sel_word < MemWordsW);

  // NOTE: every output and next-state signal gets a default first so this
  // block can never infer a latch on an unlisted path.
  always_comb begin
    ram_en_o     = 1'b0;
    ram_we_o     = '0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;
    last_d       = last_q;
    resp_owner_d = OWN_NONE;
    resp_err_d   = 1'b0;
    resp_zero_d  = 1'b0;
    if (granted) begin
      ram_addr_o   = sel_word;
      ram_wdata_o  = m1_wdata_i;
      ram_en_o     = in_range;
      if (m1_gnt_o && m1_we_i && in_range) begin
        ram_we_o = m1_be_i;
      end
      last_d       = m1_gnt_o;
      resp_owner_d = m1_gnt_o ? OWN_M1 : OWN_M0;
      resp_err_d   = !in_range;
      resp_zero_d  = !in_range || (m1_gnt_o && m1_we_i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q       <= 1'b1;
      resp_owner_q <= OWN_NONE;
      resp_err_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
    end else begin
      last_q       <= last_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  // Stores and out-of-range accesses return zero data.
  assign resp_data = resp_zero_q ? '0 : ram_rdata_i;

  always_comb begin
    m0_rvalid_o = (resp_owner_q == OWN_M0);
    m1_rvalid_o = (resp_owner_q == OWN_M1);
    m0_rdata_o  = m0_rvalid_o ? resp_data : '0;
    m1_rdata_o  = m1_rvalid_o ? resp_data : '0;
    m0_err_o    = m0_rvalid_o && resp_err_q;
    m1_err_o    = m1_rvalid_o && resp_err_q;
  end

`ifndef SYNTHESIS
  a_m0_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (m0_req_i && !m0_gnt_o) |=> (m0_req_i && $stable(m0_addr_i)));
  a_m1_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (m1_req_i && !m1_gnt_o) |=> (m1_req_i && $stable(m1_addr_i)));
`endif

endmodule
